// File: rtl/ps2_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_matrix_pkg
//  Description : Shared types and constants for the PS/2 set-2 to ZX Spectrum
//                key matrix controller. It holds the prefix FSM encoding,
//                the prefix, BAT and hot-key byte codes, the key-source
//                indices and the keymap entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_matrix_pkg;

  // Prefix sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } state_e;

  // Host hot-key decode
  typedef enum logic [1:0] {
    HOT_NONE = 2'd0,
    HOT_RST  = 2'd1,
    HOT_NMI  = 2'd2
  } hot_e;

  // Prefix bytes
  localparam logic [7:0] c_PFX_EXT   = 8'hE0;
  localparam logic [7:0] c_PFX_BRK   = 8'hF0;
  localparam logic [7:0] c_PFX_PAUSE = 8'hE1;

  // Keyboard self-test / error / overrun bytes
  localparam logic [7:0] c_BAT_OK    = 8'hAA;
  localparam logic [7:0] c_BAT_ERR0  = 8'hFC;
  localparam logic [7:0] c_BAT_ERR1  = 8'hFF;
  localparam logic [7:0] c_BAT_OVR   = 8'h00;

  // Hot-keys
  localparam logic [7:0] c_KEY_F12   = 8'h07;
  localparam logic [7:0] c_KEY_F5    = 8'h03;

  // Bytes following E1 that make up the rest of the Pause sequence
  localparam logic [2:0] c_SKIP_LEN  = 3'd7;

  // Key source index. Zero is a plain matrix key; every other value owns a
  // private bit, and each private bit drives CAPS. Sources 1..5 also force
  // a second key while held.
  localparam logic [2:0] c_SRC_NONE   = 3'd0;
  localparam logic [2:0] c_SRC_BKSP   = 3'd1;  // CAPS + 0
  localparam logic [2:0] c_SRC_LEFT   = 3'd2;  // CAPS + 5
  localparam logic [2:0] c_SRC_DOWN   = 3'd3;  // CAPS + 6
  localparam logic [2:0] c_SRC_UP     = 3'd4;  // CAPS + 7
  localparam logic [2:0] c_SRC_RIGHT  = 3'd5;  // CAPS + 8
  localparam logic [2:0] c_SRC_LSHIFT = 3'd6;  // CAPS only
  localparam logic [2:0] c_SRC_RSHIFT = 3'd7;  // CAPS only

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] combo;
    hot_e       hot;
  } keymap_t;

  // Builds a mapped keymap entry
  function automatic keymap_t km(input logic [2:0] row,
                                 input logic [2:0] col,
                                 input logic [2:0] combo);
    keymap_t e;
    e.valid = 1'b1;
    e.row   = row;
    e.col   = col;
    e.combo = combo;
    e.hot   = HOT_NONE;
    return e;
  endfunction

  // True for the bytes that release every key
  function automatic logic is_bat_code(input logic [7:0] code);
    return (code == c_BAT_OK)   || (code == c_BAT_ERR0) ||
           (code == c_BAT_ERR1) || (code == c_BAT_OVR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_matrix_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_matrix_if
//  Description : Bus bundle between the PS/2 receiver and ULA side and the
//                key matrix controller.
//                  kstb   receiver byte strobe (level)
//                  code   received scancode byte
//                  addr   ULA high address byte, low bit selects half-row
//                  keys   active-low column data D4..D0
//                  rstReq one-clock reset request pulse (F12)
//                  nmiReq one-clock NMI request pulse (F5)
//                The master modport drives the receiver and address side.
//                The slave modport is the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_matrix_if;

  logic       kstb;
  logic [7:0] code;
  logic [7:0] addr;
  logic [4:0] keys;
  logic       rstReq;
  logic       nmiReq;

  modport master (
    output kstb, code, addr,
    input  keys, rstReq, nmiReq
  );

  modport slave (
    input  kstb, code, addr,
    output keys, rstReq, nmiReq
  );

endinterface
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keymap
//  Description : Combinational scancode ROM. It maps a set-2 byte and its
//                E0 flag to a matrix position, a key source index and a
//                hot-key tag.
//                  i_ext   byte was preceded by E0
//                  i_code  scancode byte
//                  o_map   {valid, row, col, combo, hot}
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keymap
  import ps2_matrix_pkg::*;
(
  input  wire logic       i_ext,
  input  wire logic [7:0] i_code,
  output keymap_t         o_map
);

  always_comb begin
    o_map     = '0;
    o_map.hot = HOT_NONE;
    if (!i_ext) begin
      case (i_code)
        // row 0: CAPS Z X C V
        8'h12: o_map = km(3'd0, 3'd0, c_SRC_LSHIFT);
        8'h59: o_map = km(3'd0, 3'd0, c_SRC_RSHIFT);
        8'h1A: o_map = km(3'd0, 3'd1, c_SRC_NONE);
        8'h22: o_map = km(3'd0, 3'd2, c_SRC_NONE);
        8'h21: o_map = km(3'd0, 3'd3, c_SRC_NONE);
        8'h2A: o_map = km(3'd0, 3'd4, c_SRC_NONE);
        // row 1: A S D F G
        8'h1C: o_map = km(3'd1, 3'd0, c_SRC_NONE);
        8'h1B: o_map = km(3'd1, 3'd1, c_SRC_NONE);
        8'h23: o_map = km(3'd1, 3'd2, c_SRC_NONE);
        8'h2B: o_map = km(3'd1, 3'd3, c_SRC_NONE);
        8'h34: o_map = km(3'd1, 3'd4, c_SRC_NONE);
        // row 2: Q W E R T
        8'h15: o_map = km(3'd2, 3'd0, c_SRC_NONE);
        8'h1D: o_map = km(3'd2, 3'd1, c_SRC_NONE);
        8'h24: o_map = km(3'd2, 3'd2, c_SRC_NONE);
        8'h2D: o_map = km(3'd2, 3'd3, c_SRC_NONE);
        8'h2C: o_map = km(3'd2, 3'd4, c_SRC_NONE);
        // row 3: 1 2 3 4 5
        8'h16: o_map = km(3'd3, 3'd0, c_SRC_NONE);
        8'h1E: o_map = km(3'd3, 3'd1, c_SRC_NONE);
        8'h26: o_map = km(3'd3, 3'd2, c_SRC_NONE);
        8'h25: o_map = km(3'd3, 3'd3, c_SRC_NONE);
        8'h2E: o_map = km(3'd3, 3'd4, c_SRC_NONE);
        // row 4: 0 9 8 7 6
        8'h45: o_map = km(3'd4, 3'd0, c_SRC_NONE);
        8'h46: o_map = km(3'd4, 3'd1, c_SRC_NONE);
        8'h3E: o_map = km(3'd4, 3'd2, c_SRC_NONE);
        8'h3D: o_map = km(3'd4, 3'd3, c_SRC_NONE);
        8'h36: o_map = km(3'd4, 3'd4, c_SRC_NONE);
        // row 5: P O I U Y
        8'h4D: o_map = km(3'd5, 3'd0, c_SRC_NONE);
        8'h44: o_map = km(3'd5, 3'd1, c_SRC_NONE);
        8'h43: o_map = km(3'd5, 3'd2, c_SRC_NONE);
        8'h3C: o_map = km(3'd5, 3'd3, c_SRC_NONE);
        8'h35: o_map = km(3'd5, 3'd4, c_SRC_NONE);
        // row 6: ENTER L K J H
        8'h5A: o_map = km(3'd6, 3'd0, c_SRC_NONE);
        8'h4B: o_map = km(3'd6, 3'd1, c_SRC_NONE);
        8'h42: o_map = km(3'd6, 3'd2, c_SRC_NONE);
        8'h3B: o_map = km(3'd6, 3'd3, c_SRC_NONE);
        8'h33: o_map = km(3'd6, 3'd4, c_SRC_NONE);
        // row 7: SPACE SYM M N B
        8'h29: o_map = km(3'd7, 3'd0, c_SRC_NONE);
        8'h14: o_map = km(3'd7, 3'd1, c_SRC_NONE);
        8'h3A: o_map = km(3'd7, 3'd2, c_SRC_NONE);
        8'h31: o_map = km(3'd7, 3'd3, c_SRC_NONE);
        8'h32: o_map = km(3'd7, 3'd4, c_SRC_NONE);
        // backspace behaves as CAPS + 0
        8'h66: o_map = km(3'd4, 3'd0, c_SRC_BKSP);
        // hot-keys stay out of the matrix (valid stays low)
        c_KEY_F12: o_map.hot = HOT_RST;
        c_KEY_F5:  o_map.hot = HOT_NMI;
        default:   o_map = '0;
      endcase
    end else begin
      case (i_code)
        8'h14: o_map = km(3'd7, 3'd1, c_SRC_NONE);   // right ctrl -> SYM
        8'h6B: o_map = km(3'd3, 3'd4, c_SRC_LEFT);
        8'h72: o_map = km(3'd4, 3'd4, c_SRC_DOWN);
        8'h75: o_map = km(3'd4, 3'd3, c_SRC_UP);
        8'h74: o_map = km(3'd4, 3'd2, c_SRC_RIGHT);
        default: o_map = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_matrix
//  Description : PS/2 set-2 scancode to ZX Spectrum 8x5 key matrix controller.
//                It detects the rising edge of the receiver strobe, runs the
//                E0/F0/E1 prefix sequencer and keeps the matrix. It also
//                answers ULA half-row reads and pulses the reset and NMI
//                requests on the F12 and F5 hot-keys.
//                  clock  system clock
//                  reset  asynchronous active-low reset
//                  bus    slave side of ps2_matrix_if
//                         (kstb, code, addr in; keys, rstReq, nmiReq out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_matrix
  import ps2_matrix_pkg::*;
#(
  parameter bit BAT_CLEAR = 1'b1
) (
  input  wire logic    clock,
  input  wire logic    reset,
  ps2_matrix_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Byte acceptance: kstb may be high for several clocks, so one byte is
  // taken on its rising edge only.
  // --------------------------------------------------------------------------
  logic r_kstb_d;
  logic w_accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_kstb_d <= 1'b0;
    else        r_kstb_d <= bus.kstb;
  end

  assign w_accept = bus.kstb & ~r_kstb_d;

  // --------------------------------------------------------------------------
  // Prefix sequencer
  // --------------------------------------------------------------------------
  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_skip_cnt;
  logic [2:0] w_skip_next;
  logic       w_bat;
  logic       w_ext;
  logic       w_apply;  // byte is a key event to look up
  logic       w_make;   // 1 = make, 0 = break
  logic       w_clear;  // release every key

  assign w_bat = BAT_CLEAR && is_bat_code(bus.code);
  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXTBRK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_skip_cnt <= w_skip_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip_cnt;
    w_apply      = 1'b0;
    w_make       = 1'b0;
    w_clear      = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_bat) begin
            w_clear = 1'b1;
          end else if (bus.code == c_PFX_EXT) begin
            w_state_next = ST_EXT;
          end else if (bus.code == c_PFX_BRK) begin
            w_state_next = ST_BRK;
          end else if (bus.code == c_PFX_PAUSE) begin
            w_state_next = ST_SKIP;
            w_skip_next  = c_SKIP_LEN;
          end else begin
            w_apply = 1'b1;
            w_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (w_bat) begin
            w_clear      = 1'b1;
            w_state_next = ST_IDLE;
          end else if (bus.code == c_PFX_BRK) begin
            w_state_next = ST_EXTBRK;
          end else if (bus.code == c_PFX_EXT) begin
            w_state_next = ST_EXT;
          end else begin
            w_apply      = 1'b1;
            w_make       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          w_state_next = ST_IDLE;
          if (w_bat) w_clear = 1'b1;
          else       w_apply = 1'b1;
        end
        ST_SKIP: begin
          // Pause bytes are swallowed whatever their value
          w_skip_next = r_skip_cnt - 3'd1;
          if (r_skip_cnt <= 3'd1) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scancode lookup
  // --------------------------------------------------------------------------
  keymap_t w_map;

  ps2_keymap u_keymap (
    .i_ext  (w_ext),
    .i_code (bus.code),
    .o_map  (w_map)
  );

  // --------------------------------------------------------------------------
  // Key state: plain keys live in r_rows. Shifts and combo keys each own a
  // private bit in r_src (index = source - 1), so releasing one CAPS source
  // cannot cancel another.
  // --------------------------------------------------------------------------
  logic [7:0][4:0] r_rows;
  logic [6:0]      r_src;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rows <= '0;
      r_src  <= '0;
    end else if (w_clear) begin
      r_rows <= '0;
      r_src  <= '0;
    end else if (w_apply && w_map.valid) begin
      if (w_map.combo == c_SRC_NONE) r_rows[w_map.row][w_map.col] <= w_make;
      else                           r_src[w_map.combo - 3'd1]    <= w_make;
    end
  end

  // Matrix as the ULA sees it: private bits folded onto CAPS and their keys
  logic [7:0][4:0] w_eff;

  always_comb begin
    w_eff       = r_rows;
    w_eff[0][0] = r_rows[0][0] | (|r_src);
    w_eff[4][0] = r_rows[4][0] | r_src[c_SRC_BKSP  - 3'd1];
    w_eff[3][4] = r_rows[3][4] | r_src[c_SRC_LEFT  - 3'd1];
    w_eff[4][4] = r_rows[4][4] | r_src[c_SRC_DOWN  - 3'd1];
    w_eff[4][3] = r_rows[4][3] | r_src[c_SRC_UP    - 3'd1];
    w_eff[4][2] = r_rows[4][2] | r_src[c_SRC_RIGHT - 3'd1];
  end

  // --------------------------------------------------------------------------
  // ULA read path: OR together every selected half-row
  // --------------------------------------------------------------------------
  logic [4:0] w_sel;

  always_comb begin
    w_sel = '0;
    for (int n = 0; n < 8; n++) begin
      if (!bus.addr[n]) w_sel = w_sel | w_eff[n];
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  logic [4:0] r_keys;
  logic       r_rst_req;
  logic       r_nmi_req;
  logic       w_hot_rst;
  logic       w_hot_nmi;

  // Hot-keys fire on make only; breaks never reach here with w_make set
  assign w_hot_rst = w_apply && w_make && (w_map.hot == HOT_RST);
  assign w_hot_nmi = w_apply && w_make && (w_map.hot == HOT_NMI);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_keys    <= 5'h1F;
      r_rst_req <= 1'b0;
      r_nmi_req <= 1'b0;
    end else begin
      r_keys    <= ~w_sel;
      r_rst_req <= w_hot_rst;
      r_nmi_req <= w_hot_nmi;
    end
  end

  assign bus.keys   = r_keys;
  assign bus.rstReq = r_rst_req;
  assign bus.nmiReq = r_nmi_req;

endmodule
`default_nettype wire

// File: tb/tb_ps2_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_matrix
//  Description : Directed self-checking bench for ps2_matrix. Bytes are
//                driven on the falling edge and outputs sampled on the
//                falling edge. Expected key columns are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_matrix;

  logic clk;
  logic rst_n;

  ps2_matrix_if bus ();

  ps2_matrix #(.BAT_CLEAR(1'b1)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rst    = 0;
  int n_nmi    = 0;

  // Count high cycles of each request pulse
  always @(negedge clk) begin
    if (bus.rstReq === 1'b1) n_rst++;
    if (bus.nmiReq === 1'b1) n_nmi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with keys settled
  task automatic send(input logic [7:0] b, input int hold);
    bus.code = b;
    bus.kstb = 1'b1;
    repeat (hold) @(negedge clk);
    bus.kstb = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic read(input string tag, input logic [7:0] a,
                      input logic [4:0] exp);
    bus.addr = a;
    @(negedge clk);
    check_eq(tag, {27'd0, bus.keys}, {27'd0, exp});
  endtask

  int r0;
  int m0;

  initial begin
    rst_n    = 1'b0;
    bus.kstb = 1'b0;
    bus.code = 8'h00;
    bus.addr = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_keys",   {27'd0, bus.keys}, 32'h1F);
    check_eq("rst_rstreq", {31'd0, bus.rstReq}, 32'd0);
    check_eq("rst_nmireq", {31'd0, bus.nmiReq}, 32'd0);

    // A make: pre-update value on the acceptance clock, new value one later
    bus.addr = 8'hFD;
    @(negedge clk);
    bus.code = 8'h1C;
    bus.kstb = 1'b1;
    @(negedge clk);
    bus.kstb = 1'b0;
    check_eq("a_make_accept_clk", {27'd0, bus.keys}, 32'h1F);
    @(negedge clk);
    check_eq("a_make_next_clk", {27'd0, bus.keys}, 32'h1E);
    send(8'hF0, 1); send(8'h1C, 1);
    read("a_break", 8'hFD, 5'h1F);

    // Long strobes accept once: a 5-clock F0 must not re-arm as break-of-F0
    send(8'h1C, 5);
    read("a_long_make", 8'hFD, 5'h1E);
    send(8'hF0, 5); send(8'h1C, 5);
    read("a_long_break", 8'hFD, 5'h1F);

    // Shift plus backspace combo on CAPS
    send(8'h12, 1);
    read("lsh_caps", 8'hFE, 5'h1E);
    send(8'h66, 1);
    read("bksp_caps", 8'hFE, 5'h1E);
    read("bksp_zero", 8'hEF, 5'h1E);
    send(8'hF0, 1); send(8'h66, 1);
    read("bksp_rel_zero", 8'hEF, 5'h1F);
    read("bksp_rel_caps", 8'hFE, 5'h1E);
    send(8'hF0, 1); send(8'h12, 1);
    read("lsh_rel_caps", 8'hFE, 5'h1F);

    // Right shift plus cursor left (CAPS + 5)
    send(8'h59, 1); send(8'hE0, 1); send(8'h6B, 1);
    read("left_caps", 8'hFE, 5'h1E);
    read("left_five", 8'hF7, 5'h0F);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h6B, 1);
    read("left_rel_caps", 8'hFE, 5'h1E);
    read("left_rel_five", 8'hF7, 5'h1F);
    send(8'hF0, 1); send(8'h59, 1);
    read("rsh_rel_caps", 8'hFE, 5'h1F);

    // Cursor up (CAPS + 7), extended break, bare 75 ignored
    send(8'hE0, 1); send(8'h75, 1);
    read("up_seven", 8'hEF, 5'h17);
    read("up_caps", 8'hFE, 5'h1E);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    read("up_rel_seven", 8'hEF, 5'h1F);
    read("up_rel_caps", 8'hFE, 5'h1F);
    send(8'h75, 1);
    read("bare75", 8'h00, 5'h1F);

    // Pause sequence swallowed, then Z
    bus.addr = 8'h00;
    send(8'hE1, 1); check_eq("pause0", {27'd0, bus.keys}, 32'h1F);
    send(8'h14, 1); check_eq("pause1", {27'd0, bus.keys}, 32'h1F);
    send(8'h77, 1); check_eq("pause2", {27'd0, bus.keys}, 32'h1F);
    send(8'hE1, 1); check_eq("pause3", {27'd0, bus.keys}, 32'h1F);
    send(8'hF0, 1); check_eq("pause4", {27'd0, bus.keys}, 32'h1F);
    send(8'h14, 1); check_eq("pause5", {27'd0, bus.keys}, 32'h1F);
    send(8'hF0, 1); check_eq("pause6", {27'd0, bus.keys}, 32'h1F);
    send(8'h77, 1); check_eq("pause7", {27'd0, bus.keys}, 32'h1F);
    send(8'h1A, 1);
    read("z_after_pause", 8'hFE, 5'h1D);

    // BAT clear releases everything
    send(8'h1C, 1); send(8'h15, 1); send(8'h16, 1);
    read("multi_all_rows", 8'h00, 5'h1C);
    send(8'hAA, 1);
    read("bat_clear", 8'h00, 5'h1F);

    // Hot-keys: F12 one-clock pulse after acceptance
    r0 = n_rst;
    m0 = n_nmi;
    bus.code = 8'h07;
    bus.kstb = 1'b1;
    @(negedge clk);
    bus.kstb = 1'b0;
    check_eq("f12_pulse_hi", {31'd0, bus.rstReq}, 32'd1);
    @(negedge clk);
    check_eq("f12_pulse_lo", {31'd0, bus.rstReq}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("f12_pulse_len", n_rst - r0, 32'd1);
    send(8'hF0, 1); send(8'h07, 1);
    check_eq("f12_break_none", n_rst - r0, 32'd1);
    send(8'h03, 1);
    check_eq("f5_pulse_len", n_nmi - m0, 32'd1);
    check_eq("f5_no_rst", n_rst - r0, 32'd1);
    read("hot_not_matrix", 8'h00, 5'h1F);

    // Reset after E0 discards the prefix
    send(8'hE0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read("midrst_keys", 8'hFD, 5'h1F);
    send(8'h1C, 1);
    read("midrst_a", 8'hFD, 5'h1E);

    // Multi-row OR
    send(8'h15, 1);
    read("or_a_q", 8'hF9, 5'h1E);
    send(8'h1D, 1);
    read("or_a_q_w", 8'hF9, 5'h1C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
